// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the data-RAM access controller.
package mem_pkg;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic [1:0] TYPE_BYTE       = 2'b00;
    localparam logic [1:0] TYPE_HALFWORD   = 2'b01;
    localparam logic [1:0] TYPE_WORD       = 2'b10;
    localparam logic [1:0] TYPE_DOUBLEWORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    function automatic logic [63:0] size_mask(input logic [1:0] typ);
        case (typ)
            TYPE_BYTE:     return 64'h0000_0000_0000_00ff;
            TYPE_HALFWORD: return 64'h0000_0000_0000_ffff;
            TYPE_WORD:     return 64'h0000_0000_ffff_ffff;
            default:       return 64'hffff_ffff_ffff_ffff;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [1:0] typ, input logic [2:0] addr_lo);
        case (typ)
            TYPE_HALFWORD:   return addr_lo[0] == 1'b0;
            TYPE_WORD:       return addr_lo[1:0] == 2'b00;
            TYPE_DOUBLEWORD: return addr_lo == 3'b000;
            default:         return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_extend.sv
// Size extension: keeps the low 8/16/32/64 bits of din and fills the rest
// with the sign bit (sgn = 1) or zeros. With sgn = 0 it doubles as the store mask.
module mem_extend
    import mem_pkg::*;
(
    input  logic [1:0]  typ,
    input  logic        sgn,
    input  logic [63:0] din,
    output logic [63:0] dout
);

    logic [63:0] mask;
    logic        sign_bit;

    always_comb begin
        mask = size_mask(typ);
        case (typ)
            TYPE_BYTE:     sign_bit = din[7];
            TYPE_HALFWORD: sign_bit = din[15];
            TYPE_WORD:     sign_bit = din[31];
            default:       sign_bit = din[63];
        endcase
        dout = (din & mask) | ((sgn && sign_bit) ? ~mask : 64'd0);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller for the 256x8 data RAM: alignment check, RAM strobes, extended response.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | ready for a request; request fields are latched on handshake
// ST_ACCESS | ram_enable high, waiting for ram_mv (or timeout)
// ST_RESP   | rsp_valid high, holding result until rsp_ready
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [1:0]        req_type,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [1:0]        ram_type,
    output logic              ram_enable,
    input  logic              ram_mv
);

    if (DATA_W != 64 || TIMEOUT < 1 || TIMEOUT > 15) begin : g_param_check
        $error("mem_access_ctrl: DATA_W must be 64 and TIMEOUT must be 1..15");
    end

    state_t            state, state_nxt;
    logic              load_req, done_ok, done_err, req_aligned;
    logic              r_rw, r_signed;
    logic [1:0]        r_type;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, rdata_q, load_ext, store_masked;
    logic              err_q;

    assign req_aligned = is_aligned(req_type, req_addr[2:0]);

`ifdef MEM_TIMEOUT_EN
    logic [3:0] tmo_cnt;
    logic       tmo_hit;

    assign tmo_hit = (tmo_cnt == 4'(TIMEOUT - 1));

    // Held at zero outside ACCESS, so every access starts from a clean count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_cnt <= 4'd0;
        else if (state != ST_ACCESS)
            tmo_cnt <= 4'd0;
        else if (!ram_mv)
            tmo_cnt <= tmo_cnt + 4'd1;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_req  = 1'b0;
        done_ok   = 1'b0;
        done_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    load_req  = 1'b1;
                    state_nxt = req_aligned ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                if (ram_mv) begin
                    done_ok   = 1'b1;
                    state_nxt = ST_RESP;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_hit) begin
                    done_err  = 1'b1;
                    state_nxt = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    mem_extend u_load_ext (
        .typ  (r_type),
        .sgn  (r_signed),
        .din  (ram_dout),
        .dout (load_ext)
    );

    mem_extend u_store_mask (
        .typ  (r_type),
        .sgn  (1'b0),
        .din  (r_wdata),
        .dout (store_masked)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rw     <= RW_READ;
            r_type   <= TYPE_BYTE;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (load_req) begin
                r_rw     <= req_rw;
                r_type   <= req_type;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                rdata_q  <= '0;
                err_q    <= ~req_aligned;
            end
            if (done_ok) begin
                rdata_q <= (r_rw == RW_READ) ? load_ext : '0;
                err_q   <= 1'b0;
            end
            if (done_err) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign ram_enable = (state == ST_ACCESS);
    assign rsp_valid  = (state == ST_RESP);
    assign rsp_err    = rsp_valid & err_q;
    assign rsp_rdata  = rsp_valid ? rdata_q : '0;
    assign ram_rw     = r_rw;
    assign ram_type   = r_type;
    assign ram_addr   = r_addr;
    assign ram_din    = store_masked;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a little-endian byte RAM model driving ram_mv.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_rw, req_signed;
    logic [1:0]  req_type;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata, ram_din, ram_dout;
    logic        ram_rw, ram_enable, ram_mv;
    logic [7:0]  ram_addr;
    logic [1:0]  ram_type;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(8), .DATA_W(64), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_type(req_type), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .ram_din(ram_din),
        .ram_dout(ram_dout), .ram_rw(ram_rw), .ram_addr(ram_addr),
        .ram_type(ram_type), .ram_enable(ram_enable), .ram_mv(ram_mv)
    );

    typedef struct { logic [63:0] rdata; logic err; } exp_t;
    exp_t exp_q[$];

    logic [7:0]  ram_mem [256];
    logic [7:0]  ref_mem [256];
    int          checks = 0, errors = 0;
    int          mv_delay = 0, mv_cnt, en_cycles;
    bit          commit;
    logic        cm_rw;
    logic [1:0]  cm_type;
    logic [7:0]  cm_addr;
    logic [63:0] cm_din;

    // RAM model: mv after mv_delay cycles of enable; writes land on the cycle after mv.
    initial begin
        ram_mv = 1'b0; ram_dout = '0; mv_cnt = 0; commit = 0; en_cycles = 0;
        forever begin
            @(posedge clk); #1;
            if (commit) begin
                if (cm_rw == RW_WRITE)
                    for (int i = 0; i < (1 << cm_type); i++) ram_mem[8'(cm_addr + i)] = cm_din[8*i +: 8];
                commit = 0;
            end
            ram_mv = 1'b0;
            if (ram_enable) begin
                en_cycles++;
                if (mv_cnt == mv_delay) begin
                    ram_mv = 1'b1;
                    for (int i = 0; i < 8; i++) ram_dout[8*i +: 8] = ram_mem[8'(ram_addr + i)];
                    cm_rw = ram_rw; cm_type = ram_type; cm_addr = ram_addr; cm_din = ram_din;
                    commit = 1; mv_cnt = 0;
                end else mv_cnt++;
            end else mv_cnt = 0;
        end
    end

    function automatic logic [63:0] ref_load(logic [1:0] typ, logic sgn, logic [7:0] addr);
        logic [63:0] v = '0;
        int nb = 1 << typ;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[8'(addr + i)];
        if (sgn && v[8*nb-1]) for (int i = 8*nb; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic bit ref_aligned(logic [1:0] typ, logic [7:0] addr);
        if (typ == 2'd1) return addr % 2 == 0;
        if (typ == 2'd2) return addr % 4 == 0;
        if (typ == 2'd3) return addr % 8 == 0;
        return 1;
    endfunction

    task automatic push_exp(logic rw, logic [1:0] typ, logic sgn, logic [7:0] addr, logic [63:0] wdata);
        exp_t e;
        e.err   = !ref_aligned(typ, addr);
        e.rdata = (!e.err && rw) ? ref_load(typ, sgn, addr) : 64'd0;
        if (!e.err && !rw)
            for (int i = 0; i < (1 << typ); i++) ref_mem[8'(addr + i)] = wdata[8*i +: 8];
        exp_q.push_back(e);
    endtask

    task automatic issue(logic rw, logic [1:0] typ, logic sgn, logic [7:0] addr, logic [63:0] wdata, int delay);
        int n = 0;
        while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL issue_ready: req_ready=%0b after %0d cycles, expected 1", req_ready, n);
        end
        mv_delay = delay;
        req_rw = rw; req_type = typ; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        push_exp(rw, typ, sgn, addr, wdata);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [63:0] rd, output logic er, output int lat);
        lat = 0;
        while (!rsp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        rd = rsp_rdata; er = rsp_err;
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, ram_enable, ram_rw, ram_type, ram_addr} !== {5'b10001, 2'b00, 8'h00}) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b", {req_ready, rsp_valid, rsp_err, ram_enable, ram_rw, ram_type, ram_addr}, {5'b10001, 10'b0});
        end
        checks++;
        if ({rsp_rdata, ram_din} !== 128'd0) begin
            errors++;
            $display("FAIL reset_data: rsp_rdata=%h ram_din=%h expected 0", rsp_rdata, ram_din);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_byte();
        logic [63:0] rd; logic er; int lat; exp_t e;
        issue(RW_WRITE, TYPE_BYTE, 1'b0, 8'h00, 64'h1234_5678_9abc_de9a, 2);
        wait_rsp(rd, er, lat);
        e = exp_q.pop_front();
        checks++;
        if ({rd, er} !== {e.rdata, e.err} || rsp_valid !== 1'b1) begin
            errors++; $display("FAIL store_byte_rsp: got %h/%b valid=%b expected %h/%b", rd, er, rsp_valid, e.rdata, e.err);
        end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL store_byte_latency: got %0d expected 3", lat); end
        checks++;
        if ({cm_din, cm_type, cm_rw, cm_addr} !== {64'h9a, 2'b00, 1'b0, 8'h00}) begin
            errors++; $display("FAIL store_byte_strobes: din=%h type=%b rw=%b addr=%h expected 9a/00/0/00", cm_din, cm_type, cm_rw, cm_addr);
        end
        accept();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL store_byte_release: req_ready=%b rsp_valid=%b expected 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_load_byte();
        logic [63:0] rd; logic er; int lat; exp_t e;
        logic [63:0] fixed [2];
        fixed[0] = 64'h0000_0000_0000_009a;
        fixed[1] = 64'hffff_ffff_ffff_ff9a;
        for (int s = 1; s >= 0; s--) begin
            issue(RW_READ, TYPE_BYTE, 1'(s), 8'h00, 64'd0, 1);
            wait_rsp(rd, er, lat);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e.rdata || rd !== fixed[s] || er !== e.err || lat != 2) begin
                errors++; $display("FAIL load_byte_s%0d: got %h err=%b lat=%0d expected %h err=%b lat=2", s, rd, er, lat, fixed[s], e.err);
            end
            accept();
        end
    endtask

    task automatic test_misaligned();
        logic [63:0] rd; logic er; int lat; exp_t e; int en0;
        logic [1:0] tt [3];
        logic [7:0] aa [3];
        tt[0] = TYPE_HALFWORD;   aa[0] = 8'h03;
        tt[1] = TYPE_WORD;       aa[1] = 8'h0a;
        tt[2] = TYPE_DOUBLEWORD; aa[2] = 8'h0c;
        for (int k = 0; k < 3; k++) begin
            en0 = en_cycles;
            issue(RW_READ, tt[k], 1'b1, aa[k], 64'd0, 0);
            wait_rsp(rd, er, lat);
            e = exp_q.pop_front();
            checks++;
            if (er !== 1'b1 || er !== e.err || rd !== 64'd0 || lat != 0 || en_cycles != en0) begin
                errors++; $display("FAIL misaligned_%0d: err=%b rdata=%h lat=%0d en_cycles=%0d expected 1/0/0/0", k, er, rd, lat, en_cycles - en0);
            end
            accept();
        end
    endtask

    task automatic test_doubleword();
        logic [63:0] rd; logic er; int lat; exp_t e;
        logic [1:0] tt [5];
        logic       ss [5];
        logic [63:0] fixed [5];
        tt[0] = TYPE_DOUBLEWORD; ss[0] = 0; fixed[0] = 64'h0;
        tt[1] = TYPE_DOUBLEWORD; ss[1] = 1; fixed[1] = 64'hcafe_feaf_bebe_abee;
        tt[2] = TYPE_WORD;       ss[2] = 1; fixed[2] = 64'hffff_ffff_bebe_abee;
        tt[3] = TYPE_WORD;       ss[3] = 0; fixed[3] = 64'h0000_0000_bebe_abee;
        tt[4] = TYPE_HALFWORD;   ss[4] = 1; fixed[4] = 64'hffff_ffff_ffff_abee;
        for (int k = 0; k < 5; k++) begin
            issue(k == 0 ? RW_WRITE : RW_READ, tt[k], ss[k], 8'h08, 64'hcafe_feaf_bebe_abee, k);
            wait_rsp(rd, er, lat);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e.rdata || rd !== fixed[k] || er !== 1'b0 || lat != k + 1) begin
                errors++; $display("FAIL dword_%0d: got %h err=%b lat=%0d expected %h err=0 lat=%0d", k, rd, er, lat, fixed[k], k + 1);
            end
            accept();
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd, rd2; logic er; int lat, en0; exp_t e;
        issue(RW_READ, TYPE_WORD, 1'b1, 8'h0c, 64'd0, 0);
        wait_rsp(rd, er, lat);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rdata || rd !== 64'hffff_ffff_cafe_feaf || er !== 1'b0) begin
            errors++; $display("FAIL hold_first: got %h err=%b expected ffffffffcafefeaf err=0", rd, er);
        end
        mv_delay = 0;
        req_rw = RW_WRITE; req_type = TYPE_BYTE; req_signed = 1'b0; req_addr = 8'h20; req_wdata = 64'h55;
        req_valid = 1'b1;
        en0 = en_cycles;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd || req_ready !== 1'b0 || ram_enable !== 1'b0) begin
                errors++; $display("FAIL hold_cycle_%0d: valid=%b rdata=%h req_ready=%b ram_enable=%b", c, rsp_valid, rsp_rdata, req_ready, ram_enable);
            end
        end
        push_exp(RW_WRITE, TYPE_BYTE, 1'b0, 8'h20, 64'h55);
        accept();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || en_cycles != en0) begin
            errors++; $display("FAIL hold_release: req_ready=%b rsp_valid=%b enables=%0d expected 1/0/0", req_ready, rsp_valid, en_cycles - en0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(rd2, er, lat);
        e = exp_q.pop_front();
        checks++;
        if (rd2 !== e.rdata || er !== e.err || lat != 1) begin
            errors++; $display("FAIL held_store: got %h err=%b lat=%0d expected %h err=%b lat=1", rd2, er, lat, e.rdata, e.err);
        end
        accept();
        issue(RW_READ, TYPE_BYTE, 1'b0, 8'h20, 64'd0, 0);
        wait_rsp(rd2, er, lat);
        e = exp_q.pop_front();
        checks++;
        if (rd2 !== e.rdata || rd2 !== 64'h55 || er !== 1'b0) begin
            errors++; $display("FAIL held_readback: got %h expected 55", rd2);
        end
        accept();
    endtask

    task automatic test_random();
        logic [63:0] rd; logic er; int lat; exp_t e;
        logic [1:0] typ; logic [7:0] a;
        for (int k = 0; k < 12; k++) begin
            typ = 2'($urandom_range(0, 3));
            a = 8'($urandom_range(0, 255));
            if (k % 3 != 2) a = a & ~(8'((1 << typ) - 1));
            issue(1'($urandom_range(0, 1)), typ, 1'($urandom_range(0, 1)), a,
                  {$urandom, $urandom}, $urandom_range(0, 4));
            wait_rsp(rd, er, lat);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e.rdata || er !== e.err) begin
                errors++; $display("FAIL random_%0d: got %h err=%b expected %h err=%b", k, rd, er, e.rdata, e.err);
            end
            accept();
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        logic [63:0] rd; logic er; int lat; exp_t e;
        issue(RW_READ, TYPE_WORD, 1'b0, 8'h10, 64'd0, 1000);
        wait_rsp(rd, er, lat);
        e = exp_q.pop_front();
        checks++;
        if (er !== 1'b1 || rd !== 64'd0 || lat != 15 || ram_enable !== 1'b0) begin
            errors++; $display("FAIL timeout: err=%b rdata=%h lat=%0d enable=%b expected 1/0/15/0", er, rd, lat, ram_enable);
        end
        accept();
    endtask
`endif

    task automatic test_reset_mid_access();
        int seen = 0;
        issue(RW_READ, TYPE_WORD, 1'b0, 8'h10, 64'd0, 1000);
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (ram_enable !== 1'b1) begin errors++; $display("FAIL midreset_pre: ram_enable=%b expected 1", ram_enable); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, ram_enable, ram_rw, ram_type, ram_addr, rsp_rdata, ram_din} !== {5'b10001, 10'b0, 128'b0}) begin
            errors++; $display("FAIL midreset_outputs: req_ready=%b rsp_valid=%b ram_enable=%b ram_rw=%b ram_addr=%h", req_ready, rsp_valid, ram_enable, ram_rw, ram_addr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        repeat (20) begin @(posedge clk); #1; if (rsp_valid || ram_enable) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midreset_abandon: %0d active cycles after reset, expected 0", seen); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b1; req_type = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        test_reset();
        test_store_byte();
        test_load_byte();
        test_misaligned();
        test_doubleword();
        test_back_to_back();
        test_random();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
